coreir_mem_rv: RTL

//  Parametrised single-clock memory/ROM with initial contents, an optional write port and a

---
 rtl/coreir_mem_pkg.sv | 8 +
 rtl/coreir_mem_rv_if.sv | 26 ++
 rtl/coreir_mem_skid.sv | 33 +++
 rtl/coreir_mem_rv.sv | 44 ++++
 4 files changed

// File: rtl/coreir_mem_pkg.sv
// coreir_mem_pkg: shared constants and helpers for the coreir memory blocks
package coreir_mem_pkg;
  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;
  function automatic int addr_w(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/coreir_mem_rv_if.sv
// coreir_mem_rv_if: write port plus valid/ready read request and response channels
interface coreir_mem_rv_if
  import coreir_mem_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
);
  localparam int AW = addr_w(DEPTH);
  logic             wen;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic             rreq_valid;
  logic             rreq_ready;
  logic [AW-1:0]    raddr;
  logic             rresp_valid;
  logic             rresp_ready;
  logic [WIDTH-1:0] rdata;
  modport master (
    output wen, waddr, wdata, rreq_valid, raddr, rresp_ready,
    input  rreq_ready, rresp_valid, rdata
  );
  modport slave (
    input  wen, waddr, wdata, rreq_valid, raddr, rresp_ready,
    output rreq_ready, rresp_valid, rdata
  );
endinterface

// File: rtl/coreir_mem_skid.sv
// coreir_mem_skid: 2-entry valid/ready buffer, output register (head) backed by a skid register
module coreir_mem_skid #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  // ready depends only on registered state, never on out_ready
  assign in_ready = !skid_valid;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (!out_valid || out_ready) begin
      out_valid  <= skid_valid || in_valid;
      out_data   <= skid_valid ? skid_data : in_valid ? in_data : out_data;
      skid_valid <= 1'b0;
    end else if (in_valid) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end
endmodule

// File: rtl/coreir_mem_rv.sv
// coreir_mem_rv: initialised RAM/ROM with optional write port and a backpressure-tolerant read channel
module coreir_mem_rv
  import coreir_mem_pkg::*;
#(
  parameter int                     WIDTH     = 5,
  parameter int                     DEPTH     = 4,
  parameter bit                     HAS_INIT  = 1'b1,
  parameter logic [WIDTH*DEPTH-1:0] INIT      = '0,
  parameter bit                     HAS_WRITE = 1'b0,
  parameter int                     RDW_MODE  = RDW_OLD
) (
  input logic clk,
  input logic rst,
  coreir_mem_rv_if.slave bus
);
  localparam int AW = addr_w(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd;
  logic             wr;
  logic             hit;
  logic             accept;
  logic             buf_ready;
  assign wr = HAS_WRITE && !rst && bus.wen && 32'(bus.waddr) < DEPTH;
  // each entry carries its initial value; contents survive reset
  for (genvar j = 0; j < DEPTH; j++) begin : g_mem
    logic [WIDTH-1:0] e = HAS_INIT ? INIT[j*WIDTH +: WIDTH] : '0;
    always_ff @(posedge clk) if (wr && bus.waddr == AW'(j)) e <= bus.wdata;
    assign mem[j] = e;
  end
  assign hit = wr && RDW_MODE == RDW_NEW && bus.waddr == bus.raddr;
  assign rd = 32'(bus.raddr) >= DEPTH ? '0 : hit ? bus.wdata : mem[bus.raddr];
  assign bus.rreq_ready = !rst && buf_ready;
  assign accept = bus.rreq_valid && bus.rreq_ready;
  coreir_mem_skid #(.WIDTH(WIDTH)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_valid (accept),
    .in_data  (rd),
    .in_ready (buf_ready),
    .out_valid(bus.rresp_valid),
    .out_ready(bus.rresp_ready),
    .out_data (bus.rdata)
  );
endmodule
